// File: rtl/execute_unit.sv
// execute_unit: single-cycle RV32I decode, execute and data-memory access stage.
// Everything is combinational except the sticky halt/fault flags.
module execute_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        wen,
  output logic [31:0] wdata,
  output logic [31:0] dnpc,
  output logic [31:0] aluout,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        halt,
  output logic        fault
);

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IALU   = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK    = 32'h00100073;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_r, is_ialu, is_load, is_store, is_lui, is_auipc;
  logic        is_jal, is_jalr, is_branch, is_ebreak, legal;
  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b;
  logic        misaligned, exec_ok, writes_rd, br_taken;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        halt_q, halt_d, fault_q, fault_d;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];

  // Opcode decode and legality of func3/func7 for each known opcode.
  always_comb begin
    is_r = 1'b0; is_ialu = 1'b0; is_load = 1'b0; is_store = 1'b0;
    is_lui = 1'b0; is_auipc = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    is_branch = 1'b0; is_ebreak = 1'b0; legal = 1'b0;
    case (opcode)
      OP_R: begin
        is_r  = 1'b1;
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_IALU: begin
        is_ialu = 1'b1;
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        is_load = 1'b1;
        legal   = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OP_STORE: begin
        is_store = 1'b1;
        legal    = (funct3 <= 3'b010);
      end
      OP_LUI:    begin is_lui = 1'b1;   legal = 1'b1; end
      OP_AUIPC:  begin is_auipc = 1'b1; legal = 1'b1; end
      OP_JAL:    begin is_jal = 1'b1;   legal = 1'b1; end
      OP_JALR: begin
        is_jalr = 1'b1;
        legal   = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        legal     = (funct3[2:1] != 2'b01);
      end
      OP_SYSTEM: begin
        is_ebreak = (inst == EBREAK);
        legal     = is_ebreak;
      end
      default: legal = 1'b0;
    endcase
  end

  // Immediate extraction by instruction format.
  always_comb begin
    case (opcode)
      OP_IALU, OP_LOAD, OP_JALR, OP_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'b0};
      OP_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = 32'b0;
    endcase
  end

  // ALU operation select; inst[30] distinguishes sub (R only) and sra/srai.
  always_comb begin
    alu_op = ALU_ADD;
    if (is_r || is_ialu) begin
      case (funct3)
        3'b000:  alu_op = (is_r && inst[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = inst[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end else if (is_lui) begin
      alu_op = ALU_PASSB;
    end else if (is_branch) begin
      alu_op = ALU_SUB;
    end
  end

  assign alu_a = (is_auipc || is_jal) ? pc : src1;
  assign alu_b = (is_r || is_branch) ? src2 : imm;

  // ALU datapath; shifts take the low five bits of operand B.
  always_comb begin
    case (alu_op)
      ALU_ADD:   aluout = alu_a + alu_b;
      ALU_SUB:   aluout = alu_a - alu_b;
      ALU_SLL:   aluout = alu_a << alu_b[4:0];
      ALU_SLT:   aluout = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  aluout = {31'b0, alu_a < alu_b};
      ALU_XOR:   aluout = alu_a ^ alu_b;
      ALU_SRL:   aluout = alu_a >> alu_b[4:0];
      ALU_SRA:   aluout = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_OR:    aluout = alu_a | alu_b;
      ALU_AND:   aluout = alu_a & alu_b;
      ALU_PASSB: aluout = alu_b;
      default:   aluout = 32'b0;
    endcase
  end

  // Branch condition evaluated directly on the register operands.
  always_comb begin
    case (funct3)
      3'b000:  br_taken = (src1 == src2);
      3'b001:  br_taken = (src1 != src2);
      3'b100:  br_taken = ($signed(src1) < $signed(src2));
      3'b101:  br_taken = ($signed(src1) >= $signed(src2));
      3'b110:  br_taken = (src1 < src2);
      3'b111:  br_taken = (src1 >= src2);
      default: br_taken = 1'b0;
    endcase
  end

  // funct3[1:0] encodes access size for both loads and stores.
  assign misaligned = (is_load || is_store) && legal &&
                      ((funct3[1:0] == 2'b01 && aluout[0]) ||
                       (funct3[1:0] == 2'b10 && aluout[1:0] != 2'b00));
  assign exec_ok    = legal && !misaligned && !halt_q;
  assign writes_rd  = is_r || is_ialu || is_load || is_lui || is_auipc || is_jal || is_jalr;

  assign mem_valid = (is_load || is_store) && exec_ok;
  assign mem_wen   = is_store && exec_ok;
  assign mem_addr  = {aluout[31:2], 2'b00};

  // Store lane placement: data replicated across lanes, mask selects the live ones.
  always_comb begin
    mem_wmask = 4'b0000;
    case (funct3[1:0])
      2'b00:   mem_wdata = {4{src2[7:0]}};
      2'b01:   mem_wdata = {2{src2[15:0]}};
      default: mem_wdata = src2;
    endcase
    if (mem_wen) begin
      case (funct3[1:0])
        2'b00:   mem_wmask = 4'b0001 << aluout[1:0];
        2'b01:   mem_wmask = 4'b0011 << aluout[1:0];
        default: mem_wmask = 4'b1111;
      endcase
    end
  end

  // Load lane extraction with sign/zero extension.
  always_comb begin
    case (aluout[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = aluout[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  assign wen   = writes_rd && exec_ok && (rd != 5'd0);
  assign wdata = (is_jal || is_jalr) ? pc + 32'd4 : (is_load ? ld_data : aluout);

  // Next PC; a halted core or an ebreak holds the PC in place.
  always_comb begin
    if (halt_q || is_ebreak)       dnpc = pc;
    else if (!legal)               dnpc = pc + 32'd4;
    else if (is_jal)               dnpc = aluout;
    else if (is_jalr)              dnpc = {aluout[31:1], 1'b0};
    else if (is_branch && br_taken) dnpc = pc + imm;
    else                           dnpc = pc + 32'd4;
  end

  // Sticky flag updates; a halted core retires nothing, so it cannot fault.
  always_comb begin
    halt_d  = halt_q | is_ebreak;
    fault_d = fault_q | (!halt_q && (!legal || misaligned));
  end

  // Halt/fault registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      halt_q  <= halt_d;
      fault_q <= fault_d;
    end
  end

  assign halt  = halt_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed vector table, hand-written halt/fault sequences,
// and random instructions checked against an ISA-level reference model.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, pc, src1, src2, mem_rdata;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, wdata, dnpc, aluout, mem_addr, mem_wdata;
  logic        wen, mem_valid, mem_wen, halt, fault;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBRK   = 32'h00100073;

  execute_unit dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .src1(src1), .src2(src2),
    .mem_rdata(mem_rdata), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .wen(wen), .wdata(wdata), .dnpc(dnpc), .aluout(aluout),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .halt(halt), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    bit          wen;
    logic [31:0] wdata;
    logic [31:0] dnpc;
    bit          mval;
    bit          mwen;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mmask;
    bit          set_halt;
    bit          set_fault;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] inst, pc, s1, s2, word;
    bit          wen;
    logic [31:0] wdata, dnpc;
    bit          mval, mwen;
    logic [3:0]  mask;
    logic [31:0] mwdata, maddr;
  } vec_t;

  vec_t vecs[$];

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, r1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {im, r1, f3, d, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2, r1,
                                        input logic [2:0] f3);
    return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2, r1,
                                        input logic [2:0] f3);
    return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] im, input logic [4:0] d, input logic [6:0] op);
    return {im[31:12], d, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_f(input logic [2:0] f3, input bit alt, input logic [31:0] x, y);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, pcv, a, b, word, input bit halted);
    exp_t e;
    logic [6:0]  op = ins[6:0];
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] iI = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] iS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] iB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [31:0] iU = {ins[31:12], 12'b0};
    logic [31:0] iJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    logic [31:0] res = 0, ea = 0, v;
    bit bad = 0, wr = 0, ld = 0, st = 0, brk = 0, misal = 0, tk = 0;
    int size = 4, off = 0;
    e = '{default: 0};
    e.dnpc = pcv + 4;
    case (op)
      7'h33: begin
        bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        res = alu_f(f3, f7[5], a, b); wr = 1;
      end
      7'h13: begin
        e.imm = iI;
        if (f3 == 1) bad = (f7 != 0);
        else if (f3 == 5) bad = !(f7 == 0 || f7 == 7'h20);
        res = alu_f(f3, (f3 == 5) && f7[5], a, iI); wr = 1;
      end
      7'h03: begin e.imm = iI; bad = (f3 == 3 || f3 == 6 || f3 == 7); ld = 1; ea = a + iI; wr = 1; end
      7'h23: begin e.imm = iS; bad = (f3 > 2); st = 1; ea = a + iS; end
      7'h37: begin e.imm = iU; res = iU; wr = 1; end
      7'h17: begin e.imm = iU; res = pcv + iU; wr = 1; end
      7'h6F: begin e.imm = iJ; res = pcv + 4; e.dnpc = pcv + iJ; wr = 1; end
      7'h67: begin e.imm = iI; bad = (f3 != 0); res = pcv + 4; e.dnpc = (a + iI) & ~32'd1; wr = 1; end
      7'h63: begin
        e.imm = iB; bad = (f3 == 2 || f3 == 3);
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 0;
        endcase
        if (tk) e.dnpc = pcv + iB;
      end
      7'h73: begin e.imm = iI; brk = (ins == 32'h00100073); bad = !brk; end
      default: bad = 1;
    endcase
    if (ld || st) begin
      size = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
      off = int'(ea[1:0]);
      misal = (off % size) != 0;
      e.maddr = {ea[31:2], 2'b00};
      e.mval = 1;
    end
    if (ld) begin
      v = word >> (8 * off);
      if (size == 1) begin v = v & 32'hFF;   if (!f3[2] && v[7])  v = v | 32'hFFFFFF00; end
      if (size == 2) begin v = v & 32'hFFFF; if (!f3[2] && v[15]) v = v | 32'hFFFF0000; end
      res = v;
    end
    if (st) begin
      e.mwen = 1;
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + size) e.mmask[i] = 1'b1;
        e.mwdata[8*i +: 8] = b[8*(i % size) +: 8];
      end
    end
    e.wen = wr;
    e.wdata = res;
    if (bad) begin e.wen = 0; e.mval = 0; e.mwen = 0; e.mmask = 0; e.dnpc = pcv + 4; end
    if (misal) begin e.wen = 0; e.mval = 0; e.mwen = 0; e.mmask = 0; end
    if (ins[11:7] == 0) e.wen = 0;
    if (brk) e.dnpc = pcv;
    if (halted) begin e.wen = 0; e.mval = 0; e.mwen = 0; e.mmask = 0; e.dnpc = pcv; end
    e.set_halt  = brk;
    e.set_fault = !halted && (bad || misal);
    return e;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic apply(input logic [31:0] i_, p_, a_, b_, w_);
    @(posedge clk); #1;
    inst = i_; pc = p_; src1 = a_; src2 = b_; mem_rdata = w_;
    #4;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; inst = NOP;
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
  endtask

  task automatic add_v(input string nm, input logic [31:0] i_, p_, a_, b_, w_,
                       input bit e_wen, input logic [31:0] e_wdata, e_dnpc,
                       input bit e_mval, e_mwen, input logic [3:0] e_mask,
                       input logic [31:0] e_mwdata, e_maddr);
    vec_t v;
    v.nm = nm; v.inst = i_; v.pc = p_; v.s1 = a_; v.s2 = b_; v.word = w_;
    v.wen = e_wen; v.wdata = e_wdata; v.dnpc = e_dnpc; v.mval = e_mval;
    v.mwen = e_mwen; v.mask = e_mask; v.mwdata = e_mwdata; v.maddr = e_maddr;
    vecs.push_back(v);
  endtask

  task automatic cmp_model(input string tag, input exp_t e);
    chk({tag, " rs1"}, {27'b0, rs1}, {27'b0, inst[19:15]});
    chk({tag, " rs2"}, {27'b0, rs2}, {27'b0, inst[24:20]});
    chk({tag, " rd"},  {27'b0, rd},  {27'b0, inst[11:7]});
    chk({tag, " imm"}, imm, e.imm);
    chk({tag, " wen"}, {31'b0, wen}, {31'b0, e.wen});
    if (e.wen) chk({tag, " wdata"}, wdata, e.wdata);
    chk({tag, " dnpc"}, dnpc, e.dnpc);
    chk({tag, " mem_valid"}, {31'b0, mem_valid}, {31'b0, e.mval});
    chk({tag, " mem_wen"}, {31'b0, mem_wen}, {31'b0, e.mwen});
    chk({tag, " mem_wmask"}, {28'b0, mem_wmask}, {28'b0, e.mmask});
    if (e.mval) chk({tag, " mem_addr"}, mem_addr, e.maddr);
    if (e.mwen) chk({tag, " mem_wdata"}, mem_wdata, e.mwdata);
  endtask

  function automatic logic [31:0] rand_inst();
    int k = $urandom_range(0, 40);
    logic [4:0]  r1 = 5'($urandom), r2 = 5'($urandom), d = 5'($urandom);
    logic [2:0]  f3 = 3'($urandom);
    logic [11:0] im = 12'($urandom);
    logic [2:0]  ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  br_f3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [6:0]  f7;
    if (k <= 3) begin
      f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 15) == 0) f7 = 7'($urandom);
      return enc_r(f7, r2, r1, f3, d);
    end
    if (k <= 8) begin
      if (f3 == 1) im[11:5] = 7'h00;
      if (f3 == 5) im[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return enc_i(im, r1, f3, d, 7'h13);
    end
    if (k <= 13) return enc_i(im, r1, ld_f3[$urandom_range(0, 4)], d, 7'h03);
    if (k <= 18) return enc_s(im, r2, r1, 3'($urandom_range(0, 2)));
    if (k <= 20) return enc_u($urandom, d, 7'h37);
    if (k <= 22) return enc_u($urandom, d, 7'h17);
    if (k <= 25) return enc_j(21'($urandom), d);
    if (k <= 28) return enc_i(im, r1, 3'd0, d, 7'h67);
    if (k <= 33) return enc_b(13'($urandom), r2, r1, br_f3[$urandom_range(0, 5)]);
    if (k == 39) return EBRK;
    return $urandom;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    exp_t e;
    bit   mh, mf;
    logic [31:0] ri, rp, ra, rb, rw;

    rst = 1'b1; inst = NOP; pc = 0; src1 = 0; src2 = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #4;
    chk("reset halt", {31'b0, halt}, 32'd0);
    chk("reset fault", {31'b0, fault}, 32'd0);
    $display("reset: halt=%0b fault=%0b", halt, fault);

    // name, inst, pc, src1, src2, rdata | wen, wdata, dnpc, mval, mwen, mask, mwdata, maddr
    add_v("add",   enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd1), 32'h1000, 32'hFFFFFFF0, 32'h10, 0,
          1, 32'h0, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("sub",   enc_r(7'h20, 5'd3, 5'd2, 3'd0, 5'd1), 32'h1000, 32'hFFFFFFF0, 32'h10, 0,
          1, 32'hFFFFFFE0, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("sra",   enc_r(7'h20, 5'd3, 5'd2, 3'd5, 5'd1), 32'h1000, 32'h80000000, 32'h4, 0,
          1, 32'hF8000000, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("sltu",  enc_r(7'h00, 5'd3, 5'd2, 3'd3, 5'd1), 32'h1000, 32'h1, 32'hFFFFFFFF, 0,
          1, 32'h1, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("slt",   enc_r(7'h00, 5'd3, 5'd2, 3'd2, 5'd1), 32'h1000, 32'h1, 32'hFFFFFFFF, 0,
          1, 32'h0, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("srai",  enc_i(12'h404, 5'd2, 3'd5, 5'd1, 7'h13), 32'h1000, 32'h80000000, 0, 0,
          1, 32'hF8000000, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("lb3",   enc_i(12'h003, 5'd2, 3'd0, 5'd1, 7'h03), 32'h1000, 32'h2000, 0, 32'h80FF7F01,
          1, 32'hFFFFFF80, 32'h1004, 1, 0, 4'b0000, 0, 32'h2000);
    add_v("lbu3",  enc_i(12'h003, 5'd2, 3'd4, 5'd1, 7'h03), 32'h1000, 32'h2000, 0, 32'h80FF7F01,
          1, 32'h00000080, 32'h1004, 1, 0, 4'b0000, 0, 32'h2000);
    add_v("lh2",   enc_i(12'h002, 5'd2, 3'd1, 5'd1, 7'h03), 32'h1000, 32'h2000, 0, 32'h80FF7F01,
          1, 32'hFFFF80FF, 32'h1004, 1, 0, 4'b0000, 0, 32'h2000);
    add_v("lw0",   enc_i(12'h000, 5'd2, 3'd2, 5'd1, 7'h03), 32'h1000, 32'h2000, 0, 32'h80FF7F01,
          1, 32'h80FF7F01, 32'h1004, 1, 0, 4'b0000, 0, 32'h2000);
    add_v("sb2",   enc_s(12'h002, 5'd3, 5'd2, 3'd0), 32'h1000, 32'h2000, 32'hAB, 0,
          0, 0, 32'h1004, 1, 1, 4'b0100, 32'hABABABAB, 32'h2000);
    add_v("sh2",   enc_s(12'h002, 5'd3, 5'd2, 3'd1), 32'h1000, 32'h2000, 32'h1234, 0,
          0, 0, 32'h1004, 1, 1, 4'b1100, 32'h12341234, 32'h2000);
    add_v("sw2",   enc_s(12'h002, 5'd3, 5'd2, 3'd2), 32'h1000, 32'h2000, 32'h55, 0,
          0, 0, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("jal",   enc_j(21'h10, 5'd1), 32'h80000000, 0, 0, 0,
          1, 32'h80000004, 32'h80000010, 0, 0, 4'b0000, 0, 0);
    add_v("jalr",  enc_i(12'h000, 5'd2, 3'd0, 5'd1, 7'h67), 32'h1000, 32'h101, 0, 0,
          1, 32'h1004, 32'h100, 0, 0, 4'b0000, 0, 0);
    add_v("bne_eq", enc_b(13'h20, 5'd3, 5'd2, 3'd1), 32'h1000, 32'h5, 32'h5, 0,
          0, 0, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("blt_tk", enc_b(13'h20, 5'd3, 5'd2, 3'd4), 32'h1000, 32'hFFFFFFFF, 32'h1, 0,
          0, 0, 32'h1020, 0, 0, 4'b0000, 0, 0);
    add_v("lui",   enc_u(32'h12345000, 5'd1, 7'h37), 32'h1000, 0, 0, 0,
          1, 32'h12345000, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("auipc", enc_u(32'h00001000, 5'd1, 7'h17), 32'h1000, 0, 0, 0,
          1, 32'h2000, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("addi_x0", enc_i(12'h005, 5'd2, 3'd0, 5'd0, 7'h13), 32'h1000, 32'h7, 0, 0,
          0, 0, 32'h1004, 0, 0, 4'b0000, 0, 0);
    add_v("illegal", 32'h0000007F, 32'h1000, 0, 0, 0,
          0, 0, 32'h1004, 0, 0, 4'b0000, 0, 0);

    foreach (vecs[n]) begin
      apply(vecs[n].inst, vecs[n].pc, vecs[n].s1, vecs[n].s2, vecs[n].word);
      chk({vecs[n].nm, " wen"}, {31'b0, wen}, {31'b0, vecs[n].wen});
      if (vecs[n].wen) chk({vecs[n].nm, " wdata"}, wdata, vecs[n].wdata);
      chk({vecs[n].nm, " dnpc"}, dnpc, vecs[n].dnpc);
      chk({vecs[n].nm, " mem_valid"}, {31'b0, mem_valid}, {31'b0, vecs[n].mval});
      chk({vecs[n].nm, " mem_wen"}, {31'b0, mem_wen}, {31'b0, vecs[n].mwen});
      chk({vecs[n].nm, " mem_wmask"}, {28'b0, mem_wmask}, {28'b0, vecs[n].mask});
      if (vecs[n].mval) chk({vecs[n].nm, " mem_addr"}, mem_addr, vecs[n].maddr);
      if (vecs[n].mwen) chk({vecs[n].nm, " mem_wdata"}, mem_wdata, vecs[n].mwdata);
      $display("vec %-8s inst=%h wen=%0b wdata=%h dnpc=%h mask=%b", vecs[n].nm, inst, wen, wdata, dnpc, mem_wmask);
    end

    // Immediate decode spot checks.
    apply(enc_b(13'h1FFC, 5'd3, 5'd2, 3'd0), 32'h1000, 1, 2, 0);
    chk("imm B neg", imm, 32'hFFFFFFFC);
    apply(enc_r(7'h00, 5'd31, 5'd17, 3'd0, 5'd9), 32'h1000, 0, 0, 0);
    chk("imm R zero", imm, 32'h0);
    chk("rs1 field", {27'b0, rs1}, 32'd17);
    chk("rs2 field", {27'b0, rs2}, 32'd31);
    chk("rd field", {27'b0, rd}, 32'd9);

    // Misaligned store sets fault on the next edge.
    do_reset();
    apply(enc_s(12'h002, 5'd3, 5'd2, 3'd2), 32'h1000, 32'h2000, 32'h55, 0);
    chk("sw mis fault before edge", {31'b0, fault}, 32'd0);
    apply(NOP, 32'h1004, 0, 0, 0);
    chk("sw mis fault after edge", {31'b0, fault}, 32'd1);
    $display("seq misaligned sw: fault=%0b", fault);
    do_reset();
    chk("fault cleared by reset", {31'b0, fault}, 32'd0);

    // Illegal opcode sets fault.
    apply(32'h0000007F, 32'h1000, 0, 0, 0);
    chk("illegal wen", {31'b0, wen}, 32'd0);
    apply(NOP, 32'h1004, 0, 0, 0);
    chk("illegal fault", {31'b0, fault}, 32'd1);
    $display("seq illegal: fault=%0b", fault);
    do_reset();

    // ebreak halts; while halted nothing retires; reset clears.
    apply(EBRK, 32'h3000, 0, 0, 0);
    chk("ebreak dnpc", dnpc, 32'h3000);
    chk("ebreak wen", {31'b0, wen}, 32'd0);
    chk("ebreak halt before edge", {31'b0, halt}, 32'd0);
    apply(enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd1), 32'h3004, 1, 2, 0);
    chk("halted halt", {31'b0, halt}, 32'd1);
    chk("halted wen", {31'b0, wen}, 32'd0);
    chk("halted dnpc", dnpc, 32'h3004);
    chk("ebreak no fault", {31'b0, fault}, 32'd0);
    apply(enc_s(12'h000, 5'd3, 5'd2, 3'd2), 32'h3004, 32'h2000, 32'h99, 0);
    chk("halted mem_wen", {31'b0, mem_wen}, 32'd0);
    chk("halted mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("halted mem_wmask", {28'b0, mem_wmask}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #4;
    chk("halt cleared by reset", {31'b0, halt}, 32'd0);
    chk("store live after reset", {31'b0, mem_wen}, 32'd1);
    $display("seq ebreak: halt=%0b mem_wen=%0b", halt, mem_wen);

    // Random instructions against the reference model.
    do_reset();
    mh = 0; mf = 0;
    for (int i = 0; i < 400; i++) begin
      if (i > 0 && i % 25 == 0) begin
        do_reset();
        mh = 0; mf = 0;
      end
      ri = rand_inst();
      rp = $urandom & 32'hFFFFFFFC;
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? ra : $urandom;
      rw = $urandom;
      apply(ri, rp, ra, rb, rw);
      chk("rnd halt", {31'b0, halt}, {31'b0, mh});
      chk("rnd fault", {31'b0, fault}, {31'b0, mf});
      e = model(ri, rp, ra, rb, rw, mh);
      cmp_model("rnd", e);
      $display("rnd %0d inst=%h halt=%0b wen=%0b dnpc=%h mval=%0b mask=%b", i, ri, mh, wen, dnpc, mem_valid, mem_wmask);
      if (e.set_halt) mh = 1;
      if (e.set_fault) mf = 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
